// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver
// Turns a stream of desired next-state bits into J/K, D and T excitations, so
// that an attached JK, D or T flip-flop follows the stream. It also tracks the
// state the flip-flop should be in and checks the flip-flop's Q against it.
//
// Each target takes two cycles. In APPLY the excitations are driven. In CHECK
// the flip-flop's Q is compared with q_model.
//
// Ports:
//   clk, reset     rising-edge clock; asynchronous active-high reset
//   tgt_valid/tgt_ready/tgt_bit   target-bit push interface (ready = !full)
//   j_out, k_out, d_out, t_out    registered excitations
//   q_in           Q fed back from the driven flip-flop
//   q_model        expected flip-flop state
//   busy           FSM active or FIFO holding targets
//   err_clr        synchronous clear of err_count / err_flag
//   err_count      saturating mismatch counter
//   err_flag       sticky mismatch flag
//
// Build option: define FF_EXC_JK_TOGGLE_FILL_EN to fill the JK don't-cares so
// that J==K. This makes a real 0->1 or 1->0 change use toggle mode.
module ff_excitation_driver #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             tgt_bit,
    output logic             j_out,
    output logic             k_out,
    output logic             d_out,
    output logic             t_out,
    input  logic             q_in,
    output logic             q_model,
    output logic             busy,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count,
    output logic             err_flag
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]       state;
    logic [DEPTH-1:0] fifo_mem;
    // The pointers carry one extra wrap bit, so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head;
    logic             cur_tgt;
    logic             j_nxt;
    logic             k_nxt;
    logic             d_nxt;
    logic             t_nxt;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tgt_ready = !full;
    assign push      = tgt_valid && !full;
    assign pop       = !empty && (state == IDLE || state == CHECK);
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    // The excitations take the FIFO head as the target, starting from q_model.
    always_comb begin
        d_nxt = head;
        t_nxt = q_model ^ head;
`ifdef FF_EXC_JK_TOGGLE_FILL_EN
        j_nxt = q_model ^ head;
        k_nxt = q_model ^ head;
`else
        j_nxt = !q_model && head;
        k_nxt = q_model && !head;
`endif
    end

    // The storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= tgt_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cur_tgt <= 1'b0;
            q_model <= 1'b0;
            j_out   <= 1'b0;
            k_out   <= 1'b0;
            d_out   <= 1'b0;
            t_out   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);

            case (state)
                IDLE, CHECK: begin
                    if (!empty) begin
                        state   <= APPLY;
                        cur_tgt <= head;
                        j_out   <= j_nxt;
                        k_out   <= k_nxt;
                        d_out   <= d_nxt;
                        t_out   <= t_nxt;
                    end else begin
                        state   <= IDLE;
                    end
                end
                APPLY: begin
                    // The flip-flop samples on this edge. After it, drive
                    // hold values, so no flip-flop type moves again during
                    // CHECK or IDLE.
                    state   <= CHECK;
                    q_model <= cur_tgt;
                    j_out   <= 1'b0;
                    k_out   <= 1'b0;
                    t_out   <= 1'b0;
                    d_out   <= cur_tgt;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // If a clear and a mismatch land on the same edge, the clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
            err_flag  <= 1'b0;
        end else if (err_clr) begin
            err_count <= '0;
            err_flag  <= 1'b0;
        end else if (state == CHECK && q_in != q_model) begin
            if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
            err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Scoreboard bench for ff_excitation_driver. An accepted push queues the
// expected excitations and the new model state. A negedge monitor pops the
// queue whenever the DUT is in APPLY. It checks the excitations there, and
// checks q_model and the hold values in the CHECK cycle that follows.
module tb_ff_excitation_driver;

    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tgt_valid, tgt_ready, tgt_bit;
    logic       j_out, k_out, d_out, t_out;
    logic       q_in, q_model, busy, err_clr, err_flag;
    logic [7:0] err_count;

    // Second instance: narrow counter, Q tied low, used for the saturation check.
    logic       zero_q = 1'b0;
    logic       r2, j2, k2, d2, t2, qm2, b2, f2;
    logic [1:0] c2;

    logic [1:0] mode;        // 0 = JK, 1 = D, 2 = T
    logic       force_en, force_val, ffq;

    typedef struct packed { logic j; logic k; logic d; logic t; logic q; } exp_t;
    exp_t sb[$];
    logic qexp;
    logic pend_v, pend_q;
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    ff_excitation_driver #(.DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_bit(tgt_bit), .j_out(j_out), .k_out(k_out), .d_out(d_out),
        .t_out(t_out), .q_in(q_in), .q_model(q_model), .busy(busy),
        .err_clr(err_clr), .err_count(err_count), .err_flag(err_flag));

    ff_excitation_driver #(.DEPTH(4), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(r2),
        .tgt_bit(tgt_bit), .j_out(j2), .k_out(k2), .d_out(d2),
        .t_out(t2), .q_in(zero_q), .q_model(qm2), .busy(b2),
        .err_clr(err_clr), .err_count(c2), .err_flag(f2));

    // The attached flip-flop shares the DUT reset.
    always @(posedge clk or posedge reset) begin
        if (reset) ffq <= 1'b0;
        else case (mode)
            2'd0: case ({j_out, k_out})
                      2'b00: ffq <= ffq;
                      2'b01: ffq <= 1'b0;
                      2'b10: ffq <= 1'b1;
                      default: ffq <= ~ffq;
                  endcase
            2'd1: ffq <= d_out;
            default: ffq <= ffq ^ t_out;
        endcase
    end
    assign q_in = force_en ? force_val : ffq;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Hand table of the required excitations.
    task automatic sb_push(input logic b);
        exp_t e;
        logic fill;
`ifdef FF_EXC_JK_TOGGLE_FILL_EN
        fill = 1'b1;
`else
        fill = 1'b0;
`endif
        case ({qexp, b})
            2'b00:   begin e.j = 1'b0; e.k = 1'b0; end
            2'b01:   begin e.j = 1'b1; e.k = fill; end
            2'b10:   begin e.j = fill; e.k = 1'b1; end
            default: begin e.j = 1'b0; e.k = 1'b0; end
        endcase
        e.d = b;
        e.t = qexp ^ b;
        e.q = b;
        qexp = b;
        sb.push_back(e);
    endtask

    // Called at a negedge. Offers b until it is accepted, then returns at the
    // following negedge.
    task automatic push(input logic b);
        int n = 0;
        tgt_valid = 1'b1;
        tgt_bit   = b;
        while (!tgt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("push_timeout", 32'd1, 32'd0);
        end else begin
            sb_push(b);
            @(negedge clk);
        end
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
        chk({nm, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        qexp = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // The monitor checks the excitations in APPLY. In the next cycle (CHECK)
    // it checks q_model and the hold values.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                chk("q_model", {31'd0, q_model}, {31'd0, pend_q});
                chk("hold", {28'd0, j_out, k_out, d_out, t_out},
                    {28'd0, 1'b0, 1'b0, pend_q, 1'b0});
                pend_v = 1'b0;
            end
            if (dut.state == ST_APPLY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_apply", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("exc_jkdt", {28'd0, j_out, k_out, d_out, t_out},
                        {28'd0, e.j, e.k, e.d, e.t});
                    pend_q = e.q;
                    pend_v = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        logic [0:4] basic;
        logic [0:8] fullseq;
        basic   = 5'b11001;
        fullseq = 9'b101100101;
        reset = 1'b1; tgt_valid = 1'b0; tgt_bit = 1'b0; err_clr = 1'b0;
        mode = 2'd0; force_en = 1'b0; force_val = 1'b0; qexp = 1'b0;
        pend_v = 1'b0; pend_q = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {26'd0, j_out, k_out, d_out, t_out, q_model, err_flag}, 32'd0);
        chk("rst_cnt", {24'd0, err_count}, 32'd0);
        chk("rst_ready", {31'd0, tgt_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic sequence with the JK flip-flop attached.
        for (int i = 0; i < 5; i++) push(basic[i]);
        wait_idle("basic");
        chk("basic_qmodel", {31'd0, q_model}, 32'd1);
        chk("basic_err", {23'd0, err_flag, err_count}, 32'd0);

        // Same stream shape against the T and D flip-flops.
        mode = 2'd2;
        for (int i = 0; i < 5; i++) push(~basic[i]);
        wait_idle("tff");
        chk("tff_err", {24'd0, err_count}, 32'd0);
        mode = 2'd1;
        for (int i = 0; i < 5; i++) push(basic[i]);
        wait_idle("dff");
        chk("dff_err", {24'd0, err_count}, 32'd0);

        // FIFO full: with back-to-back offers from reset, the FIFO holds 4
        // entries after the 7th accepted push.
        do_reset();
        mode = 2'd0;
        for (int i = 0; i < 7; i++) push(fullseq[i]);
        #1;
        chk("full_ready", {31'd0, tgt_ready}, 32'd0);
        push(fullseq[7]);
        push(fullseq[8]);
        wait_idle("full");
        chk("full_err", {24'd0, err_count}, 32'd0);

        // Error path, with Q forced low.
        do_reset();
        force_en = 1'b1; force_val = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1);
        wait_idle("err3");
        chk("err3_cnt", {24'd0, err_count}, 32'd3);
        chk("err3_flag", {31'd0, err_flag}, 32'd1);
        for (int i = 0; i < 2; i++) push(1'b1);
        wait_idle("err5");
        chk("err5_cnt", {24'd0, err_count}, 32'd5);
        chk("sat_cnt", {30'd0, c2}, 32'd3);
        chk("sat_flag", {31'd0, f2}, 32'd1);
        // Raise clear in the CHECK cycle of one more mismatch.
        push(1'b1);
        n = 0;
        while (dut.state != ST_CHECK && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("clr_reach_check", {31'd0, (n >= 20)}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wait_idle("clr");
        chk("clr_cnt", {23'd0, err_flag, err_count}, 32'd0);
        chk("clr_cnt2", {29'd0, f2, c2}, 32'd0);
        force_en = 1'b0;

        // Reset mid-operation. Pushes land on 4 consecutive edges, so after
        // the 4th push returns the DUT is in its second APPLY cycle.
        do_reset();
        push(1'b1); push(1'b0); push(1'b1); push(1'b0);
        #1;
        reset = 1'b1;
        sb.delete();
        qexp = 1'b0;
        #1;
        chk("midrst_outs", {26'd0, j_out, k_out, d_out, t_out, q_model, err_flag}, 32'd0);
        chk("midrst_ready", {31'd0, tgt_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_qmodel", {31'd0, q_model}, 32'd0);
        chk("midrst_sb", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
